// File: rtl/apb_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_axi_bridge
//  Purpose  : APB completer that forwards in-window transfers as single
//             AXI4-Lite reads/writes, stretching the APB access phase.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_axi_bridge #(
    parameter logic [31:0] BaseAddr   = 32'h3000_1000,
    parameter logic [31:0] WindowSize = 32'h0000_0100
) (
    input  logic        a_clk,
    input  logic        a_reset_n,
    // APB completer
    input  logic        p_sel,
    input  logic        p_enable,
    input  logic        p_write,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    output logic        p_slverr,
    // AXI4-Lite manager
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] aw_addr,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [1:0]  b_resp,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    // 33-bit bounds so a window ending at the top of the map cannot wrap
    localparam logic [32:0] c_win_lo = {1'b0, BaseAddr};
    localparam logic [32:0] c_win_hi = {1'b0, BaseAddr} + {1'b0, WindowSize};

    logic [2:0]  r_state;
    logic        r_aw_valid, r_w_valid, r_aw_done, r_w_done;
    logic        r_b_ready, r_ar_valid, r_r_ready;
    logic        r_p_ready, r_p_slverr;
    logic [31:0] r_p_rdata, r_addr, r_wdata;

    logic [2:0]  w_state_nxt;
    logic        w_aw_valid_nxt, w_w_valid_nxt, w_aw_done_nxt, w_w_done_nxt;
    logic        w_b_ready_nxt, w_ar_valid_nxt, w_r_ready_nxt;
    logic        w_p_ready_nxt, w_p_slverr_nxt;
    logic [31:0] w_p_rdata_nxt, w_addr_nxt, w_wdata_nxt;

    logic w_setup, w_in_window, w_aw_hs, w_w_hs;
    logic w_unused;

    assign w_setup     = p_sel & ~p_enable;
    assign w_in_window = ({1'b0, p_addr} >= c_win_lo) && ({1'b0, p_addr} < c_win_hi);
    assign w_aw_hs     = r_aw_valid & aw_ready;
    assign w_w_hs      = r_w_valid & w_ready;
    // Only the error bit of the AXI response is meaningful to APB
    assign w_unused    = ^{b_resp[0], r_resp[0]};

    always_comb begin
        w_state_nxt    = r_state;
        w_aw_valid_nxt = r_aw_valid;
        w_w_valid_nxt  = r_w_valid;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        w_b_ready_nxt  = r_b_ready;
        w_ar_valid_nxt = r_ar_valid;
        w_r_ready_nxt  = r_r_ready;
        w_p_ready_nxt  = r_p_ready;
        w_p_slverr_nxt = r_p_slverr;
        w_p_rdata_nxt  = r_p_rdata;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;

        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_addr_nxt    = p_addr;
                    w_wdata_nxt   = p_wdata;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    if (!w_in_window) begin
                        w_state_nxt    = S_ERR;
                        w_p_ready_nxt  = 1'b1;
                        w_p_slverr_nxt = 1'b1;
                        w_p_rdata_nxt  = 32'h0;
                    end else if (p_write) begin
                        w_state_nxt    = S_WR_REQ;
                        w_aw_valid_nxt = 1'b1;
                        w_w_valid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = S_RD_REQ;
                        w_ar_valid_nxt = 1'b1;
                    end
                end
            end
            S_WR_REQ: begin
                // AW and W may complete in either order or together
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_hs) w_aw_valid_nxt = 1'b0;
                if (w_w_hs)  w_w_valid_nxt  = 1'b0;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt   = S_WR_RESP;
                    w_b_ready_nxt = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (b_valid) begin
                    w_state_nxt    = S_DONE;
                    w_b_ready_nxt  = 1'b0;
                    w_p_ready_nxt  = 1'b1;
                    w_p_slverr_nxt = b_resp[1];
                    w_p_rdata_nxt  = 32'h0;
                end
            end
            S_RD_REQ: begin
                if (ar_ready) begin
                    w_state_nxt    = S_RD_RESP;
                    w_ar_valid_nxt = 1'b0;
                    w_r_ready_nxt  = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (r_valid) begin
                    w_state_nxt    = S_DONE;
                    w_r_ready_nxt  = 1'b0;
                    w_p_ready_nxt  = 1'b1;
                    w_p_slverr_nxt = r_resp[1];
                    w_p_rdata_nxt  = r_data;
                end
            end
            S_DONE, S_ERR: begin
                w_state_nxt    = S_IDLE;
                w_p_ready_nxt  = 1'b0;
                w_p_slverr_nxt = 1'b0;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_aw_valid_nxt = 1'b0;
                w_w_valid_nxt  = 1'b0;
                w_b_ready_nxt  = 1'b0;
                w_ar_valid_nxt = 1'b0;
                w_r_ready_nxt  = 1'b0;
                w_p_ready_nxt  = 1'b0;
                w_p_slverr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (!a_reset_n) begin
            r_state    <= S_IDLE;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_b_ready  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_p_ready  <= 1'b0;
            r_p_slverr <= 1'b0;
            r_p_rdata  <= 32'h0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_aw_valid <= w_aw_valid_nxt;
            r_w_valid  <= w_w_valid_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            r_b_ready  <= w_b_ready_nxt;
            r_ar_valid <= w_ar_valid_nxt;
            r_r_ready  <= w_r_ready_nxt;
            r_p_ready  <= w_p_ready_nxt;
            r_p_slverr <= w_p_slverr_nxt;
            r_p_rdata  <= w_p_rdata_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    assign p_rdata  = r_p_rdata;
    assign p_ready  = r_p_ready;
    assign p_slverr = r_p_slverr;
    assign aw_valid = r_aw_valid;
    assign aw_addr  = r_addr;
    assign w_valid  = r_w_valid;
    assign w_data   = r_wdata;
    assign b_ready  = r_b_ready;
    assign ar_valid = r_ar_valid;
    assign ar_addr  = r_addr;
    assign r_ready  = r_r_ready;

endmodule
`default_nettype wire

// File: tb/tb_apb_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_axi_bridge
//  Purpose  : Randomized scoreboard bench for apb_axi_bridge with an
//             AXI4-Lite target model and a word-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_axi_bridge;

    localparam logic [31:0] BASE  = 32'h3000_1000;
    localparam logic [31:0] WSIZE = 32'h0000_0100;

    logic        a_clk = 1'b0;
    logic        a_reset_n = 1'b0;
    logic        p_sel = 1'b0, p_enable = 1'b0, p_write = 1'b0;
    logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
    logic [31:0] p_rdata;
    logic        p_ready, p_slverr;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
    logic        b_valid = 1'b0, r_valid = 1'b0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] aw_addr, ar_addr, w_data;
    logic [31:0] r_data = 32'h0;

    apb_axi_bridge #(.BaseAddr(BASE), .WindowSize(WSIZE)) dut (
        .a_clk(a_clk), .a_reset_n(a_reset_n),
        .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata),
        .p_ready(p_ready), .p_slverr(p_slverr),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    always #5 a_clk = ~a_clk;

    int cyc = 0;
    always @(posedge a_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Target behaviour knobs, set by the stimulus before each transfer
    int         cfg_awh = 0, cfg_wh = 0, cfg_arh = 0, cfg_bd = 0, cfg_rd = 0;
    logic [1:0] cfg_resp = 2'b00;

    logic [31:0] tgt_mem [64] = '{default: 32'h0};
    logic [31:0] ref_mem [64] = '{default: 32'h0};

    // Cumulative target activity, read as deltas by the monitor
    int aw_n = 0, w_n = 0, ar_n = 0, valid_seen = 0, resp_cyc = 0;

    function automatic int widx(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return int'(d[7:2]);
    endfunction

    // AXI4-Lite target: decides on values seen at the negedge, acts after the edge
    always begin : target
        bit          s_rst, s_aw, s_w, s_b, s_ar, s_r;
        logic [31:0] s_awaddr, s_wdata, s_araddr, t_waddr, t_wdata, t_raddr;
        bit          aw_got, w_got, b_pend, r_pend, b_chk_done;
        int          aw_c, w_c, ar_c, b_wait, r_wait;
        @(negedge a_clk);
        s_rst = !a_reset_n;
        s_aw = aw_valid & aw_ready;
        s_w  = w_valid & w_ready;
        s_b  = b_valid & b_ready;
        s_ar = ar_valid & ar_ready;
        s_r  = r_valid & r_ready;
        s_awaddr = aw_addr;
        s_wdata  = w_data;
        s_araddr = ar_addr;
        if (!s_rst) begin
            if (aw_valid || w_valid || ar_valid) valid_seen++;
            if (b_ready && !b_chk_done) begin
                check("b_ready_before_aw_w", {62'h0, aw_got, w_got}, 64'h3);
                b_chk_done = 1'b1;
            end
        end
        @(posedge a_clk);
        #1;
        if (s_rst) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_chk_done = 0;
            aw_c = 0; w_c = 0; ar_c = 0;
            aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
        end else begin
            if (s_aw) begin aw_got = 1; t_waddr = s_awaddr; aw_n++; end
            if (s_w)  begin w_got = 1;  t_wdata = s_wdata;  w_n++;  end
            if (s_b) begin
                if (!b_resp[1]) tgt_mem[widx(t_waddr)] = t_wdata;
                b_valid = 0; b_pend = 0; aw_got = 0; w_got = 0; b_chk_done = 0;
                resp_cyc = cyc;
            end else if (aw_got && w_got && !b_pend) begin
                b_pend = 1; b_wait = cfg_bd;
            end
            if (b_pend && !b_valid) begin
                if (b_wait == 0) begin b_valid = 1; b_resp = cfg_resp; end
                else b_wait--;
            end
            if (s_r) begin r_valid = 0; r_pend = 0; resp_cyc = cyc; end
            if (s_ar) begin ar_n++; t_raddr = s_araddr; r_pend = 1; r_wait = cfg_rd; end
            if (r_pend && !r_valid) begin
                if (r_wait == 0) begin
                    r_valid = 1; r_data = tgt_mem[widx(t_raddr)]; r_resp = cfg_resp;
                end else r_wait--;
            end
            if (aw_valid) begin aw_ready = (aw_c >= cfg_awh); aw_c++; end
            else begin aw_ready = 0; aw_c = 0; end
            if (w_valid) begin w_ready = (w_c >= cfg_wh); w_c++; end
            else begin w_ready = 0; w_c = 0; end
            if (ar_valid) begin ar_ready = (ar_c >= cfg_arh); ar_c++; end
            else begin ar_ready = 0; ar_c = 0; end
        end
    end

    typedef struct {
        bit          wr;
        bit          inwin;
        logic [31:0] rdata;
        bit          slverr;
        int          setup_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];

    int base_aw = 0, base_w = 0, base_ar = 0, base_vs = 0;
    bit prev_rdy = 1'b0;

    // Scoreboard monitor: pops one expectation per p_ready pulse
    always begin : monitor
        exp_t e;
        @(negedge a_clk);
        if (!a_reset_n) begin
            prev_rdy = 1'b0;
            base_aw = aw_n; base_w = w_n; base_ar = ar_n; base_vs = valid_seen;
        end else begin
            if (prev_rdy) check("p_ready_one_cycle", {63'h0, p_ready}, 64'h0);
            if (p_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_p_ready: got p_ready=1 with no transfer pending (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("p_rdata", {32'h0, p_rdata}, {32'h0, e.rdata});
                    check("p_slverr", {63'h0, p_slverr}, {63'h0, e.slverr});
                    if (e.inwin) begin
                        check("handshake_count",
                              {40'h0, 8'(aw_n - base_aw), 8'(w_n - base_w), 8'(ar_n - base_ar)},
                              e.wr ? 64'h010100 : 64'h000001);
                        check("ready_after_resp", 64'(cyc), 64'(resp_cyc));
                        if (e.chk_lat) check("latency", 64'(cyc + 1 - e.setup_cyc), 64'd3);
                    end else begin
                        check("oow_wait_states", 64'(cyc + 1 - e.setup_cyc), 64'd1);
                        check("oow_axi_valids", 64'(valid_seen - base_vs), 64'd0);
                    end
                    base_aw = aw_n; base_w = w_n; base_ar = ar_n; base_vs = valid_seen;
                end
            end
            prev_rdy = p_ready;
        end
    end

    // One APB transfer; called at posedge+1, returns at posedge+1
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input bit chk_lat);
        exp_t e;
        int   n;
        bit   inwin;
        cfg_resp = resp;
        inwin = (addr >= BASE) && (longint'(addr) < longint'(BASE) + longint'(WSIZE));
        e.wr = wr;
        e.inwin = inwin;
        e.chk_lat = chk_lat && inwin;
        e.setup_cyc = cyc + 1;
        if (!inwin) begin
            e.rdata = 32'h0; e.slverr = 1'b1;
        end else if (wr) begin
            e.rdata = 32'h0; e.slverr = resp[1];
            if (!resp[1]) ref_mem[widx(addr)] = data;
        end else begin
            e.rdata = ref_mem[widx(addr)]; e.slverr = resp[1];
        end
        exp_q.push_back(e);
        p_sel = 1; p_enable = 0; p_write = wr; p_addr = addr; p_wdata = data;
        @(posedge a_clk); #1;
        p_enable = 1;
        n = 0;
        do begin
            @(negedge a_clk);
            n++;
        end while (!p_ready && n < 200);
        if (!p_ready) begin
            checks++; errors++;
            $display("FAIL apb_timeout: p_ready stayed 0 for %0d cycles at addr %0h", n, addr);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        @(posedge a_clk); #1;
        p_sel = 0; p_enable = 0;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) begin @(posedge a_clk); #1; end
    endtask

    logic [31:0] oow_addr [4] = '{BASE + 32'd256, BASE - 32'd4, 32'h0, 32'h2000_0000};

    initial begin
        int          idx;
        bit          wr;
        logic [1:0]  rsp;
        a_reset_n = 0;
        repeat (8) @(posedge a_clk);
        #1;
        check("reset_apb_outputs", {30'h0, p_ready, p_slverr, p_rdata}, 64'h0);
        check("reset_axi_handshakes", {59'h0, aw_valid, w_valid, b_ready, ar_valid, r_ready}, 64'h0);
        check("reset_axi_addr", {aw_addr, ar_addr}, 64'h0);
        check("reset_w_data", {32'h0, w_data}, 64'h0);
        a_reset_n = 1;
        @(posedge a_clk); #1;

        for (int i = 0; i < 64; i++) apb_xfer(0, BASE + 32'(4 * i), $urandom, 2'b00, 1);
        for (int i = 0; i < 64; i++) apb_xfer(1, BASE + 32'(4 * i), $urandom, 2'b00, 1);
        for (int i = 0; i < 64; i++) apb_xfer(0, BASE + 32'(4 * i), $urandom, 2'b00, 1);

        // Split AW/W handshakes, then delayed AR
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 63);
            cfg_awh = (k < 20) ? $urandom_range(0, 20) : 0;
            cfg_wh  = (k < 20) ? 0 : $urandom_range(0, 20);
            apb_xfer(1, BASE + 32'(4 * idx), $urandom, 2'b00, 0);
            cfg_arh = $urandom_range(0, 20);
            apb_xfer(0, BASE + 32'(4 * idx), $urandom, 2'b00, 0);
            idle_gap();
        end
        cfg_awh = 0; cfg_wh = 0; cfg_arh = 0;

        // Slow B/R responses
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 63);
            wr  = 1'($urandom_range(0, 1));
            cfg_bd = $urandom_range(0, 20);
            cfg_rd = $urandom_range(0, 20);
            apb_xfer(wr, BASE + 32'(4 * idx), $urandom, 2'b00, 0);
            idle_gap();
        end
        cfg_bd = 0; cfg_rd = 0;

        // Out-of-window accesses and window edges
        for (int k = 0; k < 4; k++) begin
            apb_xfer(0, oow_addr[k], $urandom, 2'b00, 0);
            apb_xfer(1, oow_addr[k], $urandom, 2'b00, 0);
        end
        apb_xfer(1, BASE + 32'd252, $urandom, 2'b00, 1);
        apb_xfer(0, BASE + 32'd252, $urandom, 2'b00, 1);
        apb_xfer(1, BASE, $urandom, 2'b00, 1);
        apb_xfer(0, BASE, $urandom, 2'b00, 1);

        // Error and EXOKAY responses from the target
        for (int k = 0; k < 24; k++) begin
            idx = $urandom_range(0, 63);
            wr  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       rsp = 2'b10;
                1:       rsp = 2'b11;
                default: rsp = 2'b01;
            endcase
            apb_xfer(wr, BASE + 32'(4 * idx), $urandom, rsp, 0);
            apb_xfer(0, BASE + 32'(4 * idx), $urandom, 2'b00, 0);
        end

        // Reset while the write address is still waiting for aw_ready
        cfg_awh = 15; cfg_wh = 0;
        p_sel = 1; p_enable = 0; p_write = 1; p_addr = BASE + 32'd8; p_wdata = 32'hdead_beef;
        @(posedge a_clk); #1;
        p_enable = 1;
        check("aw_valid_before_reset", {63'h0, aw_valid}, 64'h1);
        a_reset_n = 0;
        @(posedge a_clk); #1;
        check("aw_valid_after_reset", {63'h0, aw_valid}, 64'h0);
        check("w_valid_after_reset", {63'h0, w_valid}, 64'h0);
        p_sel = 0; p_enable = 0;
        repeat (2) begin @(posedge a_clk); #1; end
        cfg_awh = 0;
        a_reset_n = 1;
        @(posedge a_clk); #1;
        apb_xfer(0, BASE + 32'd8, $urandom, 2'b00, 1);

        repeat (3) @(posedge a_clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        checks++; errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
